// File: rtl/demux_sched_pkg.sv
// Shared types for the four-channel burst scheduler.
// Holds the FSM state encoding and the channel index type.
package demux_sched_pkg;

    localparam int NUM_CHAN = 4;

    typedef logic [1:0] chan_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        GUARD = 2'd2
    } state_t;

endpackage

// File: rtl/demux_sched_rr_pick.sv
// Round-robin channel picker: next enabled index after i_Cur,
// or the lowest enabled index when i_From_Zero is set.
module demux_sched_rr_pick
    import demux_sched_pkg::*;
(
    input  logic [3:0] i_En,
    input  logic [1:0] i_Cur,
    input  logic       i_From_Zero,
    output logic [1:0] o_Idx,
    output logic       o_Found
);

    chan_t w_Base;
    chan_t w_Try;

    // Walk offsets 4..1 so the nearest enabled channel is written last
    always_comb begin
        o_Idx   = i_Cur;
        o_Found = 1'b0;
        w_Try   = i_Cur;
        w_Base  = i_From_Zero ? chan_t'(NUM_CHAN - 1) : i_Cur;
        for (int k = NUM_CHAN; k >= 1; k--) begin
            w_Try = w_Base + chan_t'(k);
            if (i_En[w_Try]) begin
                o_Idx   = w_Try;
                o_Found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_4_burst_sched.sv
// Burst scheduler feeding a registered 1-to-4 demux with guard gaps.
// Optional stall timeout enabled by defining DEMUX_SCHED_TIMEOUT_EN.
module demux_4_burst_sched
    import demux_sched_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BURST_LEN      = 4,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [3:0]       i_Chan_En,
    input  logic [3:0]       i_Chan_Ready,
    output logic [1:0]       o_Sel,
    output logic [WIDTH-1:0] o_Data0,
    output logic [WIDTH-1:0] o_Data1,
    output logic [WIDTH-1:0] o_Data2,
    output logic [WIDTH-1:0] o_Data3,
    output logic [3:0]       o_Valid,
    output logic             o_Timeout
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    state_t               r_State;
    chan_t                r_Sel;
    logic [BW-1:0]        r_Burst;
    logic [GW-1:0]        r_Guard;
    logic [NUM_CHAN-1:0]  r_Valid;
    logic [WIDTH-1:0]     r_Data [NUM_CHAN];

    logic                 w_Ready;
    logic                 w_Accept;
    logic                 w_Last;
    logic                 w_Guard_Done;
    chan_t                w_Next;
    logic                 w_Found;

    assign w_Ready      = (r_State == ROUTE) & i_Chan_Ready[r_Sel]
                          & i_Chan_En[r_Sel];
    assign w_Accept     = w_Ready & i_Valid;
    assign w_Last       = (r_Burst == BW'(BURST_LEN - 1));
    assign w_Guard_Done = (r_Guard == GW'(GUARD_CYCLES - 1));

    demux_sched_rr_pick u_pick (
        .i_En        (i_Chan_En),
        .i_Cur       (r_Sel),
        .i_From_Zero (r_State == IDLE),
        .o_Idx       (w_Next),
        .o_Found     (w_Found)
    );

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_Stall;
    logic          r_Timeout;
    assign o_Timeout = r_Timeout;
`else
    assign o_Timeout = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State   <= IDLE;
            r_Sel     <= '0;
            r_Burst   <= '0;
            r_Guard   <= '0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
            r_Stall   <= '0;
            r_Timeout <= 1'b0;
`endif
        end else begin
`ifdef DEMUX_SCHED_TIMEOUT_EN
            r_Timeout <= 1'b0;
`endif
            unique case (r_State)
                IDLE: begin
                    if (w_Found) begin
                        r_Sel   <= w_Next;
                        r_Burst <= '0;
                        r_State <= ROUTE;
                    end
                end
                ROUTE: begin
                    r_Guard <= '0;
                    if (!i_Chan_En[r_Sel]) begin
                        r_State <= GUARD;
                    end else if (w_Accept) begin
                        r_Burst <= r_Burst + 1'b1;
                        if (w_Last) r_State <= GUARD;
                    end
`ifdef DEMUX_SCHED_TIMEOUT_EN
                    // Stall = producer waiting on a sink that is not ready
                    if (w_Accept || !i_Valid) begin
                        r_Stall <= '0;
                    end else if (!i_Chan_Ready[r_Sel]) begin
                        if (r_Stall == TW'(TIMEOUT_CYCLES - 1)) begin
                            r_Stall   <= '0;
                            r_Timeout <= 1'b1;
                            r_State   <= GUARD;
                        end else begin
                            r_Stall <= r_Stall + 1'b1;
                        end
                    end
`endif
                end
                GUARD: begin
`ifdef DEMUX_SCHED_TIMEOUT_EN
                    r_Stall <= '0;
`endif
                    if (w_Guard_Done) begin
                        r_Guard <= '0;
                        r_Burst <= '0;
                        if (w_Found) begin
                            r_Sel   <= w_Next;
                            r_State <= ROUTE;
                        end else begin
                            r_State <= IDLE;
                        end
                    end else begin
                        r_Guard <= r_Guard + 1'b1;
                    end
                end
                default: r_State <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Valid <= '0;
            for (int i = 0; i < NUM_CHAN; i++) r_Data[i] <= '0;
        end else begin
            r_Valid <= w_Accept ? ({{(NUM_CHAN-1){1'b0}}, 1'b1} << r_Sel) : '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_Data[i] <= (w_Accept && r_Sel == chan_t'(i)) ? i_Data : '0;
            end
        end
    end

    assign o_Ready = w_Ready;
    assign o_Sel   = r_Sel;
    assign o_Valid = r_Valid;
    assign o_Data0 = r_Data[0];
    assign o_Data1 = r_Data[1];
    assign o_Data2 = r_Data[2];
    assign o_Data3 = r_Data[3];

endmodule

// File: tb/tb_demux_4_burst_sched.sv
// Bench for demux_4_burst_sched: generated vector tables plus
// hand-written sequences, outputs checked against a scoreboard queue.
module tb_demux_4_burst_sched;

    localparam int W  = 8;
    localparam int BL = 4;
    localparam int GC = 2;
    localparam int TO = 16;

    logic         i_Clk = 1'b0;
    logic         i_Rst_L = 1'b0;
    logic [W-1:0] i_Data = '0;
    logic         i_Valid = 1'b0;
    logic [3:0]   i_Chan_En = '0;
    logic [3:0]   i_Chan_Ready = '0;
    logic         o_Ready;
    logic [1:0]   o_Sel;
    logic [W-1:0] o_Data0, o_Data1, o_Data2, o_Data3;
    logic [3:0]   o_Valid;
    logic         o_Timeout;
    logic [W-1:0] w_D [4];

    always #5 i_Clk = ~i_Clk;

    demux_4_burst_sched #(
        .WIDTH          (W),
        .BURST_LEN      (BL),
        .GUARD_CYCLES   (GC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Data       (i_Data),
        .i_Valid      (i_Valid),
        .o_Ready      (o_Ready),
        .i_Chan_En    (i_Chan_En),
        .i_Chan_Ready (i_Chan_Ready),
        .o_Sel        (o_Sel),
        .o_Data0      (o_Data0),
        .o_Data1      (o_Data1),
        .o_Data2      (o_Data2),
        .o_Data3      (o_Data3),
        .o_Valid      (o_Valid),
        .o_Timeout    (o_Timeout)
    );

    assign w_D[0] = o_Data0;
    assign w_D[1] = o_Data1;
    assign w_D[2] = o_Data2;
    assign w_D[3] = o_Data3;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] d;
    } exp_t;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [3:0]   en;
        logic         er;
        logic [1:0]   es;
    } vec_t;

    exp_t  sb[$];
    vec_t  tbl[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    string tname = "init";

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.c%0d.%s got=%0h want=%0h",
                     tname, cyc, nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic [3:0] en, input logic [3:0] rdy,
                        input logic er, input logic [1:0] es,
                        input logic eto);
        exp_t         e;
        logic [3:0]   ev;
        logic [W-1:0] ed [4];
        i_Valid      = v;
        i_Data       = d;
        i_Chan_En    = en;
        i_Chan_Ready = rdy;
        #1;
        chk("ready", o_Ready, er);
        chk("sel", o_Sel, es);
        if (v && er) begin
            e.ch = es;
            e.d  = d;
            sb.push_back(e);
        end
        @(posedge i_Clk);
        #1;
        ev = '0;
        for (int i = 0; i < 4; i++) ed[i] = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            ev[e.ch] = 1'b1;
            ed[e.ch] = e.d;
        end
        chk("valid", o_Valid, ev);
        for (int i = 0; i < 4; i++) chk($sformatf("data%0d", i), w_D[i], ed[i]);
        chk("timeout", o_Timeout, eto);
        cyc++;
    endtask

    task automatic do_reset();
        i_Rst_L      = 1'b0;
        i_Valid      = 1'b0;
        i_Chan_En    = '0;
        i_Chan_Ready = '0;
        i_Data       = '0;
        #1;
        chk("rst_valid", o_Valid, 0);
        chk("rst_ready", o_Ready, 0);
        chk("rst_sel", o_Sel, 0);
        chk("rst_timeout", o_Timeout, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_data%0d", i), w_D[i], 0);
        sb.delete();
        @(posedge i_Clk);
        #1;
        i_Rst_L = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [1:0] next_ch(input logic [3:0] en,
                                           input logic [1:0] cur);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = 2'((int'(cur) + k) % 4);
            if (en[c]) return c;
        end
        return cur;
    endfunction

    task automatic push_vec(input logic v, input logic [W-1:0] d,
                            input logic [3:0] en, input logic er,
                            input logic [1:0] es);
        vec_t t;
        t.v  = v;
        t.d  = d;
        t.en = en;
        t.er = er;
        t.es = es;
        tbl.push_back(t);
    endtask

    // Expected schedule: one IDLE cycle, bursts of BL, GC-cycle gaps
    task automatic gen(input logic [3:0] en, input int nw,
                       input logic [W-1:0] d0);
        logic [1:0] ch;
        int         w;
        int         b;
        tbl.delete();
        push_vec(1'b1, d0, en, 1'b0, 2'd0);
        ch = next_ch(en, 2'd3);
        w  = 0;
        b  = 0;
        while (w < nw) begin
            push_vec(1'b1, W'(int'(d0) + w), en, 1'b1, ch);
            w++;
            b++;
            if (b == BL) begin
                for (int g = 0; g < GC; g++)
                    push_vec(1'b1, W'(int'(d0) + w), en, 1'b0, ch);
                ch = next_ch(en, ch);
                b  = 0;
            end
        end
        push_vec(1'b0, W'(int'(d0) + w), en, 1'b1, ch);
    endtask

    task automatic run_table(input string nm);
        tname = nm;
        do_reset();
        foreach (tbl[i])
            step(tbl[i].v, tbl[i].d, tbl[i].en, 4'hF, tbl[i].er, tbl[i].es, 1'b0);
    endtask

    initial begin
        // Reset mid-ROUTE with a word in flight on ch1
        tname = "rst_mid";
        do_reset();
        step(1'b1, 8'hA0, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'(8'hA0 + i), 4'hF, 4'hF, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'hA4, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'hA4, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'hA4, 4'hF, 4'hF, 1'b1, 2'd1, 1'b0);
        i_Valid = 1'b1;
        do_reset();
        step(1'b1, 8'hA5, 4'h0, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'hA5, 4'h0, 4'hF, 1'b0, 2'd0, 1'b0);

        gen(4'hF, 20, 8'h01);
        run_table("all_chan");
        gen(4'h5, 8, 8'h11);
        run_table("ch0_ch2");
        gen(4'h8, 10, 8'h61);
        run_table("single_ch3");

        // Disable current channel mid-burst, then disable everything
        tname = "disable";
        do_reset();
        step(1'b1, 8'h31, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h31, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'h32, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'h33, 4'hE, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h33, 4'hE, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h33, 4'hE, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h33, 4'hE, 4'hF, 1'b1, 2'd1, 1'b0);
        step(1'b1, 8'h34, 4'h0, 4'hF, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h34, 4'h0, 4'hF, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h34, 4'h0, 4'hF, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h34, 4'h0, 4'hF, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h34, 4'h4, 4'hF, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h34, 4'h4, 4'hF, 1'b1, 2'd2, 1'b0);

        // Sink stall on ch0 for 20 cycles with producer valid
        tname = "stall";
        do_reset();
        step(1'b1, 8'h50, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h50, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0);
`ifdef DEMUX_SCHED_TIMEOUT_EN
        for (int k = 1; k <= TO; k++)
            step(1'b1, 8'h51, 4'hF, 4'hE, 1'b0, 2'd0, k == TO);
        step(1'b1, 8'h51, 4'hF, 4'hE, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h51, 4'hF, 4'hE, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h51, 4'hF, 4'hE, 1'b1, 2'd1, 1'b0);
        step(1'b1, 8'h52, 4'hF, 4'hE, 1'b1, 2'd1, 1'b0);
        step(1'b0, 8'h53, 4'hF, 4'hF, 1'b1, 2'd1, 1'b0);
`else
        for (int k = 1; k <= 20; k++)
            step(1'b1, 8'h51, 4'hF, 4'hE, 1'b0, 2'd0, 1'b0);
        step(1'b1, 8'h51, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'h52, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'h53, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0);
        step(1'b0, 8'h54, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b0, 8'h54, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        step(1'b0, 8'h54, 4'hF, 4'hF, 1'b1, 2'd1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
